// File: rtl/r200_pkg.sv
// Shared types and constants for the r200 operand scoreboard.
// Slot fields are sized for the largest supported configuration; the top checks its parameters fit.
package r200_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    // Result latency codes carried on id_lat
    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2
    } lat_e;

    localparam int FWD_RF = 0;

    localparam int SB_RD_W  = 8;
    localparam int SB_CNT_W = 4;

    typedef struct packed {
        logic                vld;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_CNT_W-1:0] cnt;
    } slot_t;

endpackage

// File: rtl/r200_scoreboard_if.sv
// Decode-side bundle of the r200 scoreboard: ID operands in, stall/forwarding out.
interface r200_scoreboard_if import r200_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int MAXLAT = 2
);
    localparam int SELW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(MAXLAT + 1);

    logic                   id_valid;
    logic [NSRC*AW-1:0]     id_rs;
    logic [NSRC-1:0]        id_rs_used;
    logic [AW-1:0]          id_rd;
    logic                   id_regwr;
    logic [CW-1:0]          id_lat;
    logic                   flush;
    logic                   hold;
    logic [DEPTH*XLEN-1:0]  stg_data;
    logic [NSRC*XLEN-1:0]   rf_data;
    logic                   stall;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic [NSRC*XLEN-1:0]   fwd_data;
    logic                   issue;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwr, id_lat,
               flush, hold, stg_data, rf_data,
        input  stall, fwd_sel, fwd_data, issue
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwr, id_lat,
               flush, hold, stg_data, rf_data,
        output stall, fwd_sel, fwd_data, issue
    );

endinterface

// File: rtl/r200_sb_match.sv
// Priority match of one source address against the in-flight slots.
// Reports the youngest matching slot and whether its result is forwardable yet.
module r200_sb_match import r200_pkg::*; #(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic [AW-1:0]         i_addr,
    input  logic                  i_used,
    input  slot_t [DEPTH-1:0]     i_slots,
    output logic                  o_hit,
    output logic                  o_ready,
    output logic [SELW-1:0]       o_idx
);

    logic [SB_RD_W-1:0] w_addr;
    logic               w_live;

    assign w_addr = SB_RD_W'(i_addr);
    assign w_live = i_used && (i_addr != '0);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_hit   = 1'b0;
        o_ready = 1'b0;
        o_idx   = '0;
        // Oldest first, so the youngest match overwrites and shadows older writers of the same rd
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (w_live && i_slots[s].vld && (i_slots[s].rd == w_addr)) begin
                o_hit   = 1'b1;
                o_ready = (i_slots[s].cnt == '0);
                o_idx   = SELW'(s);
            end
        end
    end

endmodule

// File: rtl/r200_scoreboard.sv
// In-flight write tracker for the r200 pipeline: generates load-use/latency stalls
// and per-operand forwarding beside the ID stage.
module r200_scoreboard import r200_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int MAXLAT = 2
) (
    input logic               clk,
    input logic               rst,
    r200_scoreboard_if.slave  sb
);

    localparam int SELW = $clog2(DEPTH + 1);

    if (AW > SB_RD_W || MAXLAT >= (1 << SB_CNT_W)) begin : g_bad_cfg
        $error("r200_scoreboard: AW or MAXLAT exceeds slot field width");
    end

    slot_t [DEPTH-1:0]  r_slots;
    slot_t              w_new;
    logic [NSRC-1:0]    w_hit;
    logic [NSRC-1:0]    w_ready;
    logic [NSRC-1:0]    w_haz;
    logic [SELW-1:0]    w_idx [NSRC];
    logic               w_live;
    logic               w_track;
    int                 w_lat;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        r200_sb_match #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_match (
            .i_addr  (sb.id_rs[k*AW +: AW]),
            .i_used  (sb.id_rs_used[k]),
            .i_slots (r_slots),
            .o_hit   (w_hit[k]),
            .o_ready (w_ready[k]),
            .o_idx   (w_idx[k])
        );

        assign w_haz[k] = w_hit[k] & ~w_ready[k];
        assign sb.fwd_sel[k*SELW +: SELW] = w_hit[k] ? (w_idx[k] + SELW'(1)) : SELW'(FWD_RF);
        assign sb.fwd_data[k*XLEN +: XLEN] = w_hit[k] ? sb.stg_data[int'(w_idx[k])*XLEN +: XLEN]
                                                      : sb.rf_data[k*XLEN +: XLEN];
    end

    // A flushed instruction neither stalls nor issues; hold always freezes ID
    assign w_live   = sb.id_valid & ~sb.flush;
    assign sb.stall = sb.hold | (w_live & (|w_haz));
    assign sb.issue = w_live & ~sb.stall;
    assign w_track  = sb.issue & sb.id_regwr & (sb.id_rd != '0);

    always_comb begin
        w_lat = int'(sb.id_lat);
        if (w_lat > MAXLAT)    w_lat = MAXLAT;
        if (w_lat > DEPTH - 1) w_lat = DEPTH - 1;
        w_new.vld = w_track;
        w_new.rd  = SB_RD_W'(sb.id_rd);
        w_new.cnt = SB_CNT_W'(w_lat);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every slot shifts from last cycle's values.
        if (!rst) begin
            r_slots <= '0;
        end else if (!sb.hold) begin
            r_slots[0] <= w_new;
            // The slot leaving DEPTH-1 retires: WB writes the register file that same cycle
            for (int s = 1; s < DEPTH; s++) begin
                r_slots[s].vld <= r_slots[s-1].vld;
                r_slots[s].rd  <= r_slots[s-1].rd;
                r_slots[s].cnt <= (r_slots[s-1].cnt == '0) ? '0 : r_slots[s-1].cnt - SB_CNT_W'(1);
            end
        end
    end

    a_lat_range: assert property (@(posedge clk) disable iff (!rst)
        sb.id_valid |-> (int'(sb.id_lat) <= MAXLAT));

endmodule

// File: doc/r200_scoreboard.md
Name: r200_scoreboard

Overview:
Parametrised successor to the fixed hazard/forwarding logic of the r200 pipeline. It tracks in-flight register writes across DEPTH post-decode stages, including multi-cycle result latency. For each of NSRC decode-stage source operands it generates a load-use/latency stall, a forward select and the forwarded data. It sits beside the ID stage and replaces the hazard unit and the per-operand 8:1 muxes.

Parameters:
XLEN, 32, data width
AW, 5, register address width (x0 never tracked)
DEPTH, 3, tracked stages after ID (slot 0 = EX, slot DEPTH-1 = WB)
NSRC, 2, number of source operands checked per cycle
MAXLAT, 2, largest result latency accepted on issue
SELW, $clog2(DEPTH+1), forward select width
CW, $clog2(MAXLAT+1), latency counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_rs  in  NSRC*AW  source addresses, src k at [k*AW +: AW]
id_rs_used  in  NSRC  source k is actually read
id_rd  in  AW  destination address
id_regwr  in  1  instruction writes rd
id_lat  in  CW  cycles after EX before the result is forwardable (0 ALU, 1 load, 2 mul)
flush  in  1  ID instruction killed (branch/jump resolved); not issued
hold  in  1  downstream freeze; scoreboard state frozen
stg_data  in  DEPTH*XLEN  result bus of slot s at [s*XLEN +: XLEN]
rf_data  in  NSRC*XLEN  register-file read data per source
stall  out  1  freeze IF/ID, insert bubble into EX
fwd_sel  out  NSRC*SELW  0 = register file, s+1 = slot s
fwd_data  out  NSRC*XLEN  selected operand per source
issue  out  1  ID instruction accepted this cycle

Behaviour:
- State: DEPTH slots {vld, rd, cnt[CW]}; slot 0 is youngest.
- Reset (rst==0 at posedge): all vld=0, rd=0, cnt=0. Outputs are combinational from state, so after reset stall=0, issue=id_valid&~flush, fwd_sel=0, fwd_data=rf_data.
- Entry is tracked only if id_regwr==1 and id_rd!=0. Otherwise slot 0 receives a bubble (vld=0).
- Match for source k: id_rs_used[k], id_rs[k]!=0, slot vld, slot rd==id_rs[k]. Only the youngest (lowest-index) matching slot counts.
- Youngest match with cnt==0: fwd_sel=s+1, fwd_data=stg_data slot s.
- Youngest match with cnt!=0: source hazard. An older ready match is never used.
- No match: fwd_sel=0, fwd_data=rf_data[k].
- stall = hold | (id_valid & ~flush & any source hazard).
- issue = id_valid & ~flush & ~stall.
- Each posedge with rst==1 and hold==0:
  - Slots shift (s -> s+1). Slot DEPTH-1 retires, since WB writes the register file that cycle and the slot covers that write.
  - Every shifted cnt decrements, saturating at 0.
  - Slot 0 <= {issue & id_regwr & id_rd!=0, id_rd, min(id_lat, DEPTH-1)}.
- hold==1: all slots and counters keep their values.
- flush together with stall: flush wins. issue=0 and a bubble is inserted.
- id_lat > MAXLAT is clamped to MAXLAT. An SVA asserts it never occurs.
- Same rd in two slots: the younger slot shadows the older for matching.
- Latency from issue to first forwardable cycle = id_lat+1 clocks. No internal pipelining of outputs.

Decomposition:
- Package r200_pkg:
  - XLEN/AW defaults
  - latency codes LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2
  - FWD_RF=0
  - slot struct typedef {vld, rd, cnt}
- Sub-module r200_sb_match:
  - one per source (generate over NSRC)
  - priority-matches one address against the DEPTH slots
  - returns hit, ready, slot index
  - the top muxes the data

Test Plan:
1. ALU back-to-back: issue rd=5, lat=0; next cycle id_rs0=5 -> stall=0, fwd_sel0=1, fwd_data0=stg_data slot0 (0xDEADBEEF).
2. Load-use: issue rd=7, lat=1; next cycle id_rs1=7 -> stall=1 for 1 cycle, then fwd_sel1=2 from slot1.
3. Mul latency 2 with DEPTH=3: issue rd=9, lat=2, then rs0=9 -> stall 2 cycles, then fwd_sel0=3 (WB slot).
4. Shadowing: issue rd=3 lat=0, then rd=3 lat=1, then read x3 -> stall=1 (younger not ready), older ready slot ignored; x0 read always gives fwd_sel=0.
5. Flush during hazard: load rd=4, next cycle rs0=4 with flush=1 -> stall=0, issue=0, bubble in slot 0; hold=1 for 3 cycles freezes cnt.
6. Reset mid-flight: 3 valid slots, drive rst=0 one cycle -> all slots clear, rs0=any gives fwd_sel=0, stall=0.
